// File: rtl/div_monitor.sv
// div_monitor: measures the period of an asynchronous divided clock in clk
// cycles, declares lock after LOCK_CNT consecutive good periods, and flags
// errors while locked and stalls (no edge for 2*DIV cycles).
// Optional duty-cycle check: define DIV_MON_DUTY_CHECK_EN.
module div_monitor #(
  parameter int DIV      = 9,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clr,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic             stall,
  output logic [CNT_W-1:0] high_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, TRACK, LOCKED} state_t;

  // Tolerance windows, one bit wider than cnt so DIV+TOL cannot wrap.
  localparam logic [CNT_W:0] P_LO  = (CNT_W+1)'((DIV > TOL) ? DIV - TOL : 0);
  localparam logic [CNT_W:0] P_HI  = (CNT_W+1)'(DIV + TOL);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(2 * DIV);
  localparam logic [3:0] LC        = 4'(LOCK_CNT);

  state_t           state, nstate;
  logic             s1, s2, s3, e;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       mcnt, mc_nxt;
  logic             lock_nxt, err_set, stall_set;
  logic             meas, tmo, per_ok, good;

  assign e      = s2 & ~s3;
  assign meas   = enable & e & ((state == TRACK) | (state == LOCKED));
  assign tmo    = ~e & (cnt == TMO);
  assign per_ok = ({1'b0, cnt} >= P_LO) && ({1'b0, cnt} <= P_HI);

`ifdef DIV_MON_DUTY_CHECK_EN
  localparam logic [CNT_W:0] H_LO = (CNT_W+1)'((DIV/2 > TOL) ? DIV/2 - TOL : 0);
  localparam logic [CNT_W:0] H_HI = (CNT_W+1)'((DIV+1)/2 + TOL);
  logic [CNT_W-1:0] hcnt;
  logic             duty_ok;

  assign duty_ok = ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} <= H_HI);
  assign good    = per_ok & duty_ok;

  // Count synchronized-high cycles per period; the edge cycle itself is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hcnt     <= '0;
      high_cnt <= '0;
    end else begin
      if (!enable)                hcnt <= '0;
      else if (e)                 hcnt <= CNT_W'(1);
      else if (s2 && hcnt != '1)  hcnt <= hcnt + CNT_W'(1);
      if (meas) high_cnt <= hcnt;
    end
  end
`else
  assign good     = per_ok;
  assign high_cnt = '0;
`endif

  // Next-state and match/lock/flag decisions; enable low overrides everything.
  always_comb begin
    nstate    = state;
    mc_nxt    = mcnt;
    lock_nxt  = locked;
    err_set   = 1'b0;
    stall_set = 1'b0;
    if (!enable) begin
      nstate   = IDLE;
      mc_nxt   = '0;
      lock_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          nstate   = WAIT_EDGE;
          mc_nxt   = '0;
          lock_nxt = 1'b0;
        end
        WAIT_EDGE: if (e) nstate = TRACK;
        TRACK: begin
          if (tmo) begin
            stall_set = 1'b1;
            mc_nxt    = '0;
            nstate    = WAIT_EDGE;
          end else if (e) begin
            if (good) begin
              mc_nxt = mcnt + 4'd1;
              if (mc_nxt == LC) begin
                nstate   = LOCKED;
                lock_nxt = 1'b1;
              end
            end else begin
              mc_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (tmo) begin
            stall_set = 1'b1;
            mc_nxt    = '0;
            lock_nxt  = 1'b0;
            nstate    = WAIT_EDGE;
          end else if (e && !good) begin
            err_set  = 1'b1;
            mc_nxt   = '0;
            lock_nxt = 1'b0;
            nstate   = TRACK;
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  // State, synchronizer, period counter and sticky status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      mcnt       <= '0;
      locked     <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      stall      <= 1'b0;
    end else begin
      s1         <= div_in;
      s2         <= s1;
      s3         <= s2;
      state      <= nstate;
      mcnt       <= mc_nxt;
      locked     <= lock_nxt;
      period_vld <= meas;
      if (meas) period <= cnt;
      if (!enable || state == IDLE) cnt <= '0;
      else if (e)                   cnt <= CNT_W'(1);
      else if (cnt != '1)           cnt <= cnt + CNT_W'(1);
      // A new error in the same cycle as clr wins.
      if (err_set) begin
        err     <= 1'b1;
        err_cnt <= clr ? 8'd1 : ((err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1);
      end else if (clr) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
      if (stall_set) stall <= 1'b1;
      else if (clr)  stall <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_monitor.sv
// Scoreboard bench for div_monitor: a period-level model pushes the expected
// measurement at each driven rising edge; a negedge monitor pops on period_vld.
module tb_div_monitor;
  localparam int DIV = 9, TOL = 0, LOCK_CNT = 4, CNT_W = 8;

  logic clk = 1'b0;
  logic reset, enable, clr, div_in;
  logic [CNT_W-1:0] period, high_cnt;
  logic period_vld, locked, err, stall;
  logic [7:0] err_cnt;

  div_monitor #(.DIV(DIV), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr), .div_in(div_in),
    .period(period), .period_vld(period_vld), .locked(locked), .err(err),
    .err_cnt(err_cnt), .stall(stall), .high_cnt(high_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int p; int h; bit lk; bit er; int ec;} exp_t;
  exp_t sbq[$];
  exp_t mx;

  int n_chk = 0, n_fail = 0;
  int since = 0, prev_h = 0;
  int m_st = 0, m_mc = 0, m_ec = 0;   // m_st: 0 wait, 1 track, 2 locked
  bit m_lk = 0, m_err = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit is_good(int p, int h);
    bit ok;
    ok = (p >= DIV - TOL) && (p <= DIV + TOL);
`ifdef DIV_MON_DUTY_CHECK_EN
    ok = ok && (h >= DIV/2 - TOL) && (h <= (DIV+1)/2 + TOL);
`else
    if (h < 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic model_reset();
    m_st = 0; m_mc = 0; m_lk = 0;
  endtask

  task automatic model_clr();
    m_err = 0; m_ec = 0;
  endtask

  // Expected effect of a rising edge that closes a period of length p, high h.
  task automatic model_edge(int p, int h);
    exp_t x;
    bit g;
    if (m_st == 0) begin
      m_st = 1;
      return;
    end
    g = is_good(p, h);
    if (m_st == 1) begin
      if (g) begin
        m_mc++;
        if (m_mc == LOCK_CNT) begin m_st = 2; m_lk = 1; end
      end else m_mc = 0;
    end else if (!g) begin
      m_err = 1;
      m_ec  = (m_ec == 255) ? 255 : m_ec + 1;
      m_mc  = 0; m_lk = 0; m_st = 1;
    end
    x.p = p;
`ifdef DIV_MON_DUTY_CHECK_EN
    x.h = h;
`else
    x.h = 0;
`endif
    x.lk = m_lk; x.er = m_err; x.ec = m_ec;
    sbq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk); #1;
    since++;
  endtask

  // One div_in period: high h cycles, low p-h; optional clr in cycle clr_at.
  // clr_at==2 lands on the posedge that registers this edge's measurement.
  task automatic pulse(int p, int h, int clr_at = -1);
    int rp, rh;
    rp = since; rh = prev_h; since = 0; prev_h = h;
    if (clr_at >= 0 && clr_at <= 2) model_clr();
    model_edge(rp, rh);
    for (int c = 0; c < p; c++) begin
      div_in = (c < h);
      clr    = (c == clr_at);
      if (c == clr_at && c > 2) model_clr();
      step();
    end
    clr = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_vld"}, period_vld, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_high_cnt"}, high_cnt, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset === 1'b1 && period_vld === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_vld", 1, 0);
      else begin
        mx = sbq.pop_front();
        chk("period", period, mx.p);
        chk("high_cnt", high_cnt, mx.h);
        chk("locked", locked, mx.lk);
        chk("err", err, mx.er);
        chk("err_cnt", err_cnt, mx.ec);
      end
    end
  end

  initial begin
    int vi, si;
    reset = 1'b0; enable = 1'b1; clr = 1'b0; div_in = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Ideal input: lock on the 4th measured period.
    repeat (6) pulse(9, 4);
    chk("lock_ideal", locked, 1);
    chk("err_ideal", err, 0);

    // Single 10-cycle period while locked, then relock.
    pulse(10, 5);
    repeat (5) pulse(9, 4);
    chk("relock", locked, 1);

    // 300 errors with relock between each: err_cnt saturates.
    for (int n = 0; n < 300; n++) begin
      pulse(10, 5);
      repeat (4) pulse(9, 4);
    end
    pulse(9, 4);
    chk("err_cnt_sat", err_cnt, 255);

    // Stall: one more edge, then hold low.
    begin
      int rp;
      rp = since; since = 0;
      model_edge(rp, prev_h); prev_h = 4;
    end
    div_in = 1'b1; vi = 0; si = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 4) div_in = 1'b0;
      if (period_vld && vi == 0) vi = i;
      if (stall) begin si = i; break; end
    end
    chk("edge_latency", vi, 4);
    chk("stall_seen", si > 0, 1);
    chk("stall_delay", si - vi, 18);
    chk("stall_unlock", locked, 0);
    model_reset();
    step();
    repeat (6) pulse(9, 4);
    chk("lock_after_stall", locked, 1);

    // clr mid-period clears all sticky status.
    chk("stall_before_clr", stall, 1);
    pulse(9, 4, 5);
    chk("clr_err", err, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_stall", stall, 0);

    // clr coincident with a new error: the set wins (1, not 2 or 0).
    pulse(10, 5);
    repeat (5) pulse(9, 4);
    pulse(10, 5);
    pulse(9, 4, 2);
    chk("clr_vs_err", err_cnt, 1);
    repeat (4) pulse(9, 4);

    // enable low mid-operation, then re-enable.
    chk("lock_before_dis", locked, 1);
    pulse(9, 4);
    enable = 1'b0;
    step();
    chk("dis_locked", locked, 0);
    chk("dis_vld", period_vld, 0);
    repeat (3) step();
    enable = 1'b1;
    model_reset();
    repeat (6) pulse(9, 4);
    chk("lock_after_en", locked, 1);

    // Synchronous reset mid-operation.
    div_in = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk_all_zero("midreset");
    reset = 1'b1; div_in = 1'b0;
    model_reset(); model_clr();
    step();
    repeat (6) pulse(9, 4);
    chk("lock_after_reset", locked, 1);

`ifdef DIV_MON_DUTY_CHECK_EN
    // Duty check: 2-cycle high time is bad, 4/5-cycle high time locks.
    repeat (8) pulse(9, 2);
    chk("duty_bad_nolock", locked, 0);
    repeat (3) begin pulse(9, 5); pulse(9, 4); end
    chk("duty_good_lock", locked, 1);
`endif

    repeat (12) step();
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
